// File: rtl/stp_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stp_frame_ctrl
//  Description : Sequencer between the FIR output and the N-tap serial-to-
//                parallel shift chain. Gates samples into the chain, counts
//                window fill, and hands each full (optionally sliding) window
//                to the consumer with a valid/ready handshake, stalling the
//                FIR while a window is outstanding.
//  Revision    : 1.0 - initial release
// ============================================================================
module stp_frame_ctrl #(
    parameter int N      = 16,
    parameter int HOP    = 16,
    parameter int CNT_W  = 5,
    parameter int FCNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic              fir_valid_i,
    output logic              fir_ready_o,
    output logic              shift_en_o,
    output logic              stp_clr_o,
    output logic              frame_valid_o,
    input  logic              frame_ready_i,
    output logic [FCNT_W-1:0] frame_cnt_o,
    output logic [7:0]        drop_cnt_o,
    output logic              overflow_o,
    output logic              busy_o
);

    // Parameter sanity: a hop outside 1..N or a fill counter too narrow to
    // reach N cannot produce a meaningful window.
    if (HOP < 1 || HOP > N) begin : g_bad_hop
        $error("stp_frame_ctrl: HOP must lie within 1..N");
    end
    if ((2 ** CNT_W) <= N) begin : g_bad_cnt_w
        $error("stp_frame_ctrl: CNT_W too narrow to hold N");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] c_N   = CNT_W'(N);
    localparam logic [CNT_W-1:0] c_HOP = CNT_W'(HOP);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    fill_q, fill_d;
    logic                primed_q, primed_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic                overflow_q, overflow_d;
    logic                stp_clr_q, stp_clr_d;

    logic                w_ready;
    logic                w_shift;
    logic                w_drop;
    logic [CNT_W-1:0]    w_target;
    logic [CNT_W-1:0]    w_fill_inc;

    // Handshake decode: samples are only taken while filling; anything offered
    // outside FILL is a drop and never reaches the chain.
    always_comb begin
        w_ready    = (state_q == S_FILL);
        w_shift    = fir_valid_i & w_ready;
        w_drop     = fir_valid_i & ~w_ready;
        w_target   = primed_q ? c_HOP : c_N;
        w_fill_inc = fill_q + CNT_W'(1);
    end

    // Next-state logic; flush overrides everything including a handshake.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        primed_d    = primed_q;
        frame_cnt_d = frame_cnt_q;
        stp_clr_d   = 1'b0;

        if (flush_i) begin
            state_d   = S_IDLE;
            fill_d    = '0;
            primed_d  = 1'b0;
            stp_clr_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_FILL;
                    end
                end
                S_FILL: begin
                    // start is ignored here so a begun window always completes.
                    if (w_shift) begin
                        fill_d = w_fill_inc;
                        if (w_fill_inc == w_target) begin
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (frame_ready_i) begin
                        frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                        fill_d      = '0;
                        primed_d    = 1'b1;
                        state_d     = start_i ? S_FILL : S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Drop accounting: saturating counter plus sticky flag (flush leaves both).
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q | w_drop;
        if (w_drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // State and counter registers with asynchronous active-low clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            fill_q      <= '0;
            primed_q    <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            stp_clr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            primed_q    <= primed_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
            stp_clr_q   <= stp_clr_d;
        end
    end

    // Output mapping.
    always_comb begin
        fir_ready_o   = w_ready;
        shift_en_o    = w_shift;
        stp_clr_o     = stp_clr_q;
        frame_valid_o = (state_q == S_HOLD);
        frame_cnt_o   = frame_cnt_q;
        drop_cnt_o    = drop_cnt_q;
        overflow_o    = overflow_q;
        busy_o        = (state_q != S_IDLE);
    end

endmodule
`default_nettype wire
